// File: rtl/encolador_botones.sv
// Button command queue: 2-flop sync + debounce per button, priority encode of presses, small FIFO.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 edge + 1 write cycles from raw edge; cmd valid 1 cycle after rd_en.
// Backpressure: full FIFO drops presses (overflow pulse, saturating drop_cnt); CMD_DEDUP_EN drops repeat codes.
module encolador_botones #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEPTH           = 4,
    parameter int AW              = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arriba,
    input  logic       abajo,
    input  logic       izquierda,
    input  logic       derecha,
    input  logic       pausa,
    input  logic       rd_en,
    output logic [2:0] cmd,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic [7:0] drop_cnt
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    // Bit order doubles as priority order: bit 4 (pausa) wins.
    logic [4:0]    btn_raw;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [4:0]    press;
    logic [2:0]    code_d;
    logic          evt_d;

    logic          wr_vld_q;
    logic [2:0]    wr_code_q;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [2:0]    cmd_q;
    logic          ovf_q;
    logic [7:0]    drop_q;
    logic          dup;
    logic          do_wr, do_rd, ovf_d;

    assign btn_raw = {pausa, arriba, abajo, izquierda, derecha};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    always_comb begin
        code_d = 3'd0;
        if (press[4])      code_d = 3'd5;
        else if (press[3]) code_d = 3'd1;
        else if (press[2]) code_d = 3'd2;
        else if (press[1]) code_d = 3'd3;
        else if (press[0]) code_d = 3'd4;
    end
    assign evt_d = |press;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

`ifdef CMD_DEDUP_EN
    logic [2:0] last_q;
    // Pause is exempt so a pause/resume pair is never collapsed.
    assign dup = (wr_code_q == last_q) && !empty && (wr_code_q != 3'd5);
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 3'd0;
        end else if (do_wr) begin
            last_q <= wr_code_q;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_vld_q && !dup && (!full || rd_en);
    assign ovf_d = wr_vld_q && !dup && full && !rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            wr_vld_q   <= 1'b0;
            wr_code_q  <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cmd_q      <= 3'd0;
            ovf_q      <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
            wr_vld_q   <= evt_d;
            wr_code_q  <= code_d;
            if (rd_en) begin
                cmd_q <= empty ? 3'd0 : mem[rd_ptr_q];
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ovf_q <= ovf_d;
            if (ovf_d && drop_q != 8'hFF) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_code_q;
        end
    end

    assign cmd      = cmd_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_encolador_botones.sv
// Directed table-driven bench for encolador_botones (DEBOUNCE_CYCLES=8, DEPTH=4).
module tb_encolador_botones;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;  // {pausa, arriba, abajo, izquierda, derecha}
    logic       rd_en;
    logic [2:0] cmd;
    logic       empty, full, overflow;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;
    int ov_seen;

    always #5 clk = ~clk;

    encolador_botones #(.DEBOUNCE_CYCLES(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .arriba(btn[3]), .abajo(btn[2]), .izquierda(btn[1]), .derecha(btn[0]), .pausa(btn[4]),
        .rd_en(rd_en), .cmd(cmd), .empty(empty), .full(full),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [4:0] btn;
        logic       pop;
        logic [2:0] cmd;
        logic       emp;
        logic       ful;
        int         ov;
        int         drop;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input logic [4:0] b, input logic p, input logic [2:0] c,
                                input logic e, input logic f, input int o, input int d);
        row_t r;
        r.btn = b; r.pop = p; r.cmd = c; r.emp = e; r.ful = f; r.ov = o; r.drop = d;
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [4:0] m, input int hold);
        ov_seen = 0;
        btn = m;
        repeat (hold) begin
            @(negedge clk);
            ov_seen += int'(overflow);
        end
        btn = 5'b0;
        repeat (16) begin
            @(negedge clk);
            ov_seen += int'(overflow);
        end
    endtask

    task automatic pop();
        ov_seen = 0;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        ov_seen += int'(overflow);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (rows[i].pop) pop();
            else             press(rows[i].btn, 20);
            check($sformatf("row%0d_cmd", i), int'(cmd), int'(rows[i].cmd));
            check($sformatf("row%0d_empty", i), int'(empty), int'(rows[i].emp));
            check($sformatf("row%0d_full", i), int'(full), int'(rows[i].ful));
            check($sformatf("row%0d_ovf", i), ov_seen, rows[i].ov);
            check($sformatf("row%0d_drop", i), int'(drop_cnt), rows[i].drop);
        end
    endtask

    initial begin
        logic dedup;
`ifdef CMD_DEDUP_EN
        dedup = 1'b1;
`else
        dedup = 1'b0;
`endif
        //          btn       pop   cmd  emp  ful  ov drop
        rows.push_back(mk(5'b00001, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0)); // 0 derecha
        rows.push_back(mk(5'b00000, 1'b1, 3'd4, 1'b1, 1'b0, 0, 0)); // 1
        rows.push_back(mk(5'b00000, 1'b1, 3'd0, 1'b1, 1'b0, 0, 0)); // 2 pop empty
        rows.push_back(mk(5'b10100, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0)); // 3 pausa+abajo
        rows.push_back(mk(5'b00000, 1'b1, 3'd5, 1'b1, 1'b0, 0, 0)); // 4
        rows.push_back(mk(5'b01000, 1'b0, 3'd5, 1'b0, 1'b0, 0, 0)); // 5 up
        rows.push_back(mk(5'b00100, 1'b0, 3'd5, 1'b0, 1'b0, 0, 0)); // 6 down
        rows.push_back(mk(5'b00010, 1'b0, 3'd5, 1'b0, 1'b0, 0, 0)); // 7 left
        rows.push_back(mk(5'b00001, 1'b0, 3'd5, 1'b0, 1'b1, 0, 0)); // 8 right -> full
        rows.push_back(mk(5'b01000, 1'b0, 3'd5, 1'b0, 1'b1, 1, 1)); // 9 dropped
        rows.push_back(mk(5'b00000, 1'b1, 3'd1, 1'b0, 1'b0, 0, 1)); // 10
        rows.push_back(mk(5'b00000, 1'b1, 3'd2, 1'b0, 1'b0, 0, 1)); // 11
        rows.push_back(mk(5'b00000, 1'b1, 3'd3, 1'b0, 1'b0, 0, 1)); // 12
        rows.push_back(mk(5'b00000, 1'b1, 3'd4, 1'b1, 1'b0, 0, 1)); // 13
        rows.push_back(mk(5'b00010, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0)); // 14 left
        rows.push_back(mk(5'b00010, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0)); // 15 left again
        rows.push_back(mk(5'b00000, 1'b1, 3'd3, dedup, 1'b0, 0, 0)); // 16
        rows.push_back(mk(5'b00000, 1'b1, dedup ? 3'd0 : 3'd3, 1'b1, 1'b0, 0, 0)); // 17
        rows.push_back(mk(5'b10000, 1'b0, dedup ? 3'd0 : 3'd3, 1'b0, 1'b0, 0, 0)); // 18 pausa
        rows.push_back(mk(5'b10000, 1'b0, dedup ? 3'd0 : 3'd3, 1'b0, 1'b0, 0, 0)); // 19 pausa
        rows.push_back(mk(5'b00000, 1'b1, 3'd5, 1'b0, 1'b0, 0, 0)); // 20
        rows.push_back(mk(5'b00000, 1'b1, 3'd5, 1'b1, 1'b0, 0, 0)); // 21
        rows.push_back(mk(5'b00010, 1'b0, 3'd5, 1'b0, 1'b0, 0, 0)); // 22 left
        rows.push_back(mk(5'b00000, 1'b1, 3'd3, 1'b1, 1'b0, 0, 0)); // 23
        rows.push_back(mk(5'b00010, 1'b0, 3'd3, 1'b0, 1'b0, 0, 0)); // 24 left after drain
        rows.push_back(mk(5'b00000, 1'b1, 3'd3, 1'b1, 1'b0, 0, 0)); // 25

        btn = 5'b0; rd_en = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd", int'(cmd), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_drop", int'(drop_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        run_rows(0, 2);

        // Bouncing arriba never stays stable for a full window.
        ov_seen = 0;
        for (int t = 0; t < 10; t++) begin
            btn[3] = ~btn[3];
            repeat (3) @(negedge clk);
        end
        btn = 5'b0;
        repeat (20) @(negedge clk);
        check("bounce_empty", int'(empty), 1);

        run_rows(3, 13);

        // Refill, then land a pausa write on the same edge as a pop while full.
        press(5'b01000, 20);
        press(5'b00100, 20);
        press(5'b00010, 20);
        press(5'b00001, 20);
        check("refill_full", int'(full), 1);
        btn = 5'b10000;
        repeat (11) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("simul_ovf", int'(overflow), 0);
        check("simul_cmd", int'(cmd), 1);
        check("simul_full", int'(full), 1);
        ov_seen = 0;
        repeat (8) begin
            @(negedge clk);
            ov_seen += int'(overflow);
        end
        btn = 5'b0;
        repeat (16) begin
            @(negedge clk);
            ov_seen += int'(overflow);
        end
        check("simul_ovf_after", ov_seen, 0);
        check("simul_drop", int'(drop_cnt), 1);
        pop(); check("simul_pop2", int'(cmd), 2);
        pop(); check("simul_pop3", int'(cmd), 3);
        pop(); check("simul_pop4", int'(cmd), 4);
        pop(); check("simul_pop5", int'(cmd), 5);
        check("simul_empty", int'(empty), 1);

        // Reset mid-operation discards the queued entry and the drop counter.
        press(5'b00001, 20);
        check("mid_pre_empty", int'(empty), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_empty", int'(empty), 1);
        check("mid_drop", int'(drop_cnt), 0);
        check("mid_cmd", int'(cmd), 0);
        pop();
        check("mid_pop_cmd", int'(cmd), 0);

        run_rows(14, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
